// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
// vend_pkg: coin encodings, coin values in nickels, controller state encoding.
// Rev 1.0
// ============================================================================
package vend_pkg;

    localparam logic [1:0] COIN_NICKEL  = 2'b00;
    localparam logic [1:0] COIN_DIME    = 2'b01;
    localparam logic [1:0] COIN_QUARTER = 2'b10;
    localparam logic [1:0] COIN_INVALID = 2'b11;

    localparam logic [2:0] VAL_NICKEL  = 3'd1;
    localparam logic [2:0] VAL_DIME    = 3'd2;
    localparam logic [2:0] VAL_QUARTER = 3'd5;

    localparam logic [1:0] ST_ACCUM  = 2'd0;
    localparam logic [1:0] ST_VEND   = 2'd1;
    localparam logic [1:0] ST_CHANGE = 2'd2;

    typedef enum logic [1:0] {
        S_ACCUM  = ST_ACCUM,
        S_VEND   = ST_VEND,
        S_CHANGE = ST_CHANGE
    } vend_state_e;

    // Invalid code maps to zero so callers can gate on validity separately.
    function automatic logic [2:0] coin_value(input logic [1:0] code);
        case (code)
            COIN_NICKEL:  coin_value = VAL_NICKEL;
            COIN_DIME:    coin_value = VAL_DIME;
            COIN_QUARTER: coin_value = VAL_QUARTER;
            default:      coin_value = 3'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/vend_ctrl_if.sv
`default_nettype none
// ============================================================================
// vend_ctrl_if: coin acceptor / actuator / hopper signals of the vend controller.
// Optional: VEND_SALES_COUNT_EN adds sales_count. Rev 1.0
// ============================================================================
interface vend_ctrl_if #(
    parameter int CREDIT_W = 6
) ();
    import vend_pkg::*;

    logic                coin_valid;
    logic [1:0]          coin_code;
    logic                cancel;
    logic                vend_ack;
    logic                ret_ready;
    logic                coin_reject;
    logic                dispense;
    logic                ret_valid;
    logic [1:0]          ret_coin;
    logic [CREDIT_W-1:0] credit;
`ifdef VEND_SALES_COUNT_EN
    logic [15:0]         sales_count;
`endif

    // master: acceptor/actuator/hopper side; slave: the controller.
    modport master (
        output coin_valid, coin_code, cancel, vend_ack, ret_ready,
`ifdef VEND_SALES_COUNT_EN
        input  sales_count,
`endif
        input  coin_reject, dispense, ret_valid, ret_coin, credit
    );

    modport slave (
        input  coin_valid, coin_code, cancel, vend_ack, ret_ready,
`ifdef VEND_SALES_COUNT_EN
        output sales_count,
`endif
        output coin_reject, dispense, ret_valid, ret_coin, credit
    );

endinterface
`default_nettype wire

// File: rtl/vend_change_picker.sv
`default_nettype none
// ============================================================================
// vend_change_picker: largest returnable coin not exceeding the given credit.
// Rev 1.0
// ============================================================================
module vend_change_picker
    import vend_pkg::*;
#(
    parameter int CREDIT_W = 6
) (
    input  logic [CREDIT_W-1:0] credit,
    output logic [1:0]          coin,
    output logic [2:0]          value
);

    always_comb begin
        if (credit >= CREDIT_W'(VAL_QUARTER)) begin
            coin = COIN_QUARTER;
        end else if (credit >= CREDIT_W'(VAL_DIME)) begin
            coin = COIN_DIME;
        end else begin
            coin = COIN_NICKEL;
        end
        value = coin_value(coin);
    end

endmodule
`default_nettype wire

// File: rtl/vend_ctrl.sv
`default_nettype none
// ============================================================================
// vend_ctrl: credit accumulation, vend request and coin-by-coin change/refund.
// Optional: VEND_SALES_COUNT_EN adds a wrapping 16-bit vend counter. Rev 1.0
// ============================================================================
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int PRICE      = 5,
    parameter int MAX_CREDIT = 20,
    parameter int CREDIT_W   = 6
) (
    input  logic        clk,
    input  logic        reset,
    vend_ctrl_if.slave  bus
);

    localparam int                  CW1     = CREDIT_W + 1;
    localparam logic [CREDIT_W:0]   PRICE_W = CW1'(PRICE);
    localparam logic [CREDIT_W:0]   MAX_W   = CW1'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

    vend_state_e         state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                dispense_q, dispense_d;
    logic                coin_reject_q, coin_reject_d;
    logic                ret_valid_q, ret_valid_d;
    logic [1:0]          ret_coin_q, ret_coin_d;

    logic [CREDIT_W:0]   coin_sum;
    logic                coin_ok;
    logic [CREDIT_W-1:0] credit_acc;
    logic                vend_done;

    logic [1:0]          cur_coin, nxt_coin;
    logic [2:0]          cur_value, nxt_value;
    logic                unused_pick;

    // One extra bit on the sum so a coin past the ceiling can never wrap.
    assign coin_sum   = {1'b0, credit_q} + CW1'(coin_value(bus.coin_code));
    assign coin_ok    = bus.coin_valid && (bus.coin_code != COIN_INVALID) && (coin_sum <= MAX_W);
    assign credit_acc = coin_ok ? coin_sum[CREDIT_W-1:0] : credit_q;
    assign vend_done  = (state_q == S_VEND) && bus.vend_ack;

    // cur_* sizes the coin being handed over now; nxt_* sizes the next request.
    vend_change_picker #(.CREDIT_W(CREDIT_W)) u_pick_cur (
        .credit (credit_q),
        .coin   (cur_coin),
        .value  (cur_value)
    );

    vend_change_picker #(.CREDIT_W(CREDIT_W)) u_pick_nxt (
        .credit (credit_d),
        .coin   (nxt_coin),
        .value  (nxt_value)
    );

    assign unused_pick = &{1'b0, cur_coin, nxt_value};

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        coin_reject_d = bus.coin_valid;
        unique case (state_q)
            S_ACCUM: begin
                coin_reject_d = bus.coin_valid && !coin_ok;
                credit_d      = credit_acc;
                // A refund request outranks reaching the price on the same edge.
                if (bus.cancel && (credit_acc != '0)) begin
                    state_d = S_CHANGE;
                end else if ({1'b0, credit_acc} >= PRICE_W) begin
                    state_d = S_VEND;
                end
            end
            S_VEND: begin
                if (bus.vend_ack) begin
                    credit_d = credit_q - PRICE_C;
                    state_d  = (credit_d != '0) ? S_CHANGE : S_ACCUM;
                end
            end
            S_CHANGE: begin
                if (ret_valid_q && bus.ret_ready) begin
                    credit_d = credit_q - CREDIT_W'(cur_value);
                    if (credit_d == '0) begin
                        state_d = S_ACCUM;
                    end
                end
            end
            default: state_d = S_ACCUM;
        endcase
    end

    assign dispense_d  = (state_d == S_VEND);
    assign ret_valid_d = (state_d == S_CHANGE);
    assign ret_coin_d  = ret_valid_d ? nxt_coin : COIN_NICKEL;

`ifdef VEND_SALES_COUNT_EN
    logic [15:0] sales_count_q, sales_count_d;

    assign sales_count_d   = sales_count_q + 16'(vend_done);
    assign bus.sales_count = sales_count_q;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_ACCUM;
            credit_q      <= '0;
            dispense_q    <= 1'b0;
            coin_reject_q <= 1'b0;
            ret_valid_q   <= 1'b0;
            ret_coin_q    <= COIN_NICKEL;
`ifdef VEND_SALES_COUNT_EN
            sales_count_q <= 16'd0;
`endif
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            dispense_q    <= dispense_d;
            coin_reject_q <= coin_reject_d;
            ret_valid_q   <= ret_valid_d;
            ret_coin_q    <= ret_coin_d;
`ifdef VEND_SALES_COUNT_EN
            sales_count_q <= sales_count_d;
`endif
        end
    end

    assign bus.credit      = credit_q;
    assign bus.dispense    = dispense_q;
    assign bus.coin_reject = coin_reject_q;
    assign bus.ret_valid   = ret_valid_q;
    assign bus.ret_coin    = ret_coin_q;

endmodule
`default_nettype wire

// File: tb/tb_vend_ctrl.sv
`default_nettype none
// ============================================================================
// tb_vend_ctrl: directed stimulus with a return-coin scoreboard.
// Rev 1.0
// ============================================================================
module tb_vend_ctrl;
    import vend_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    vend_ctrl_if #(.CREDIT_W(6)) bus ();
    vend_ctrl_if #(.CREDIT_W(6)) ovf_bus ();

    vend_ctrl #(.PRICE(5), .MAX_CREDIT(20), .CREDIT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Price above the ceiling: credit can be pushed to the limit without vending.
    vend_ctrl #(.PRICE(30), .MAX_CREDIT(20), .CREDIT_W(6)) dut_ovf (
        .clk   (clk),
        .reset (reset),
        .bus   (ovf_bus.slave)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [1:0] ret_exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every return handshake must match the next scoreboard entry; 3'b100 marks none pending.
    always @(negedge clk) begin
        if (reset && bus.ret_valid && bus.ret_ready) begin
            logic [2:0] e;
            e = (ret_exp_q.size() != 0) ? {1'b0, ret_exp_q.pop_front()} : 3'b100;
            check("ret_coin_hs", {29'd0, 1'b0, bus.ret_coin}, {29'd0, e});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic coin(input logic [1:0] c);
        bus.coin_valid = 1'b1;
        bus.coin_code  = c;
        step();
        bus.coin_valid = 1'b0;
        bus.coin_code  = COIN_NICKEL;
    endtask

    task automatic ocoin(input logic [1:0] c);
        ovf_bus.coin_valid = 1'b1;
        ovf_bus.coin_code  = c;
        step();
        ovf_bus.coin_valid = 1'b0;
        ovf_bus.coin_code  = COIN_NICKEL;
    endtask

    task automatic outs(input string tag, input int cr, input logic d, input logic rv,
                        input logic [1:0] rc, input logic rj);
        check({tag, ".credit"},   32'(bus.credit),      cr);
        check({tag, ".dispense"}, 32'(bus.dispense),    32'(d));
        check({tag, ".ret_valid"},32'(bus.ret_valid),   32'(rv));
        check({tag, ".ret_coin"}, 32'(bus.ret_coin),    32'(rc));
        check({tag, ".reject"},   32'(bus.coin_reject), 32'(rj));
    endtask

    task automatic pulse_ack();
        bus.vend_ack = 1'b1;
        step();
        bus.vend_ack = 1'b0;
    endtask

    task automatic pulse_cancel();
        bus.cancel = 1'b1;
        step();
        bus.cancel = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        bus.coin_valid = 1'b0;  bus.coin_code = COIN_NICKEL; bus.cancel = 1'b0;
        bus.vend_ack   = 1'b0;  bus.ret_ready = 1'b0;
        ovf_bus.coin_valid = 1'b0; ovf_bus.coin_code = COIN_NICKEL; ovf_bus.cancel = 1'b0;
        ovf_bus.vend_ack   = 1'b0; ovf_bus.ret_ready = 1'b0;
        step();
        step();
        outs("reset", 0, 1'b0, 1'b0, 2'b00, 1'b0);
        check("ovf_reset.credit", 32'(ovf_bus.credit), 0);
        reset = 1'b1;

        // Exact price, no change.
        coin(COIN_QUARTER);
        outs("q_vend", 5, 1'b1, 1'b0, 2'b00, 1'b0);
        repeat (3) step();
        check("q_hold.dispense", 32'(bus.dispense), 1);
        pulse_ack();
        outs("q_ack", 0, 1'b0, 1'b0, 2'b00, 1'b0);
        step();
        outs("q_idle", 0, 1'b0, 1'b0, 2'b00, 1'b0);

        // Overpay by four nickels: two dimes back, with a stalled hopper first.
        coin(COIN_DIME);
        coin(COIN_DIME);
        outs("dd", 4, 1'b0, 1'b0, 2'b00, 1'b0);
        coin(COIN_QUARTER);
        outs("ddq", 9, 1'b1, 1'b0, 2'b00, 1'b0);
        ret_exp_q.push_back(COIN_DIME);
        ret_exp_q.push_back(COIN_DIME);
        pulse_ack();
        outs("ddq_ack", 4, 1'b0, 1'b1, COIN_DIME, 1'b0);
        step();
        step();
        outs("stall", 4, 1'b0, 1'b1, COIN_DIME, 1'b0);
        bus.ret_ready = 1'b1;
        step();
        outs("chg1", 2, 1'b0, 1'b1, COIN_DIME, 1'b0);
        step();
        outs("chg2", 0, 1'b0, 1'b0, 2'b00, 1'b0);
        bus.ret_ready = 1'b0;

        // Cancel refund: dime then nickel.
        coin(COIN_NICKEL);
        coin(COIN_DIME);
        outs("nd", 3, 1'b0, 1'b0, 2'b00, 1'b0);
        ret_exp_q.push_back(COIN_DIME);
        ret_exp_q.push_back(COIN_NICKEL);
        pulse_cancel();
        outs("cancel", 3, 1'b0, 1'b1, COIN_DIME, 1'b0);
        bus.ret_ready = 1'b1;
        step();
        outs("refund1", 1, 1'b0, 1'b1, COIN_NICKEL, 1'b0);
        step();
        outs("refund2", 0, 1'b0, 1'b0, 2'b00, 1'b0);
        bus.ret_ready = 1'b0;
        pulse_cancel();
        outs("cancel0", 0, 1'b0, 1'b0, 2'b00, 1'b0);

        // Rejections: invalid code, coin during VEND; cancel ignored in VEND.
        coin(COIN_INVALID);
        outs("invalid", 0, 1'b0, 1'b0, 2'b00, 1'b1);
        step();
        check("invalid_end.reject", 32'(bus.coin_reject), 0);
        coin(COIN_QUARTER);
        coin(COIN_NICKEL);
        outs("vend_coin", 5, 1'b1, 1'b0, 2'b00, 1'b1);
        pulse_cancel();
        outs("vend_cancel", 5, 1'b1, 1'b0, 2'b00, 1'b0);
        pulse_ack();
        outs("vend3_ack", 0, 1'b0, 1'b0, 2'b00, 1'b0);
`ifdef VEND_SALES_COUNT_EN
        check("sales_count", 32'(bus.sales_count), 3);
`endif

        // Credit ceiling on the high-price instance.
        for (int i = 1; i <= 4; i++) begin
            ocoin(COIN_QUARTER);
            check("ovf_fill.credit", 32'(ovf_bus.credit), 32'(5 * i));
            check("ovf_fill.reject", 32'(ovf_bus.coin_reject), 0);
        end
        ocoin(COIN_QUARTER);
        check("ovf_q.reject", 32'(ovf_bus.coin_reject), 1);
        check("ovf_q.credit", 32'(ovf_bus.credit), 20);
        ocoin(COIN_NICKEL);
        check("ovf_n.reject", 32'(ovf_bus.coin_reject), 1);
        check("ovf_n.credit", 32'(ovf_bus.credit), 20);
        check("ovf.dispense", 32'(ovf_bus.dispense), 0);

        // Reset while a refund is being offered.
        coin(COIN_DIME);
        pulse_cancel();
        outs("pre_rst", 2, 1'b0, 1'b1, COIN_DIME, 1'b0);
        reset = 1'b0;
        step();
        outs("mid_rst", 0, 1'b0, 1'b0, 2'b00, 1'b0);
        check("ovf_mid_rst.credit", 32'(ovf_bus.credit), 0);
`ifdef VEND_SALES_COUNT_EN
        check("sales_count_rst", 32'(bus.sales_count), 0);
`endif
        reset = 1'b1;
        step();
        outs("post_rst", 0, 1'b0, 1'b0, 2'b00, 1'b0);

        check("ret_scoreboard_empty", 32'(ret_exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
